// File: rtl/simple_uart_arbiter.sv
// Round-robin arbiter sharing one simple_uart_core register port
// between NumReq requesters, with per-owner lock and lock timeout.
module simple_uart_arbiter #(
   parameter int NumReq        = 4,
   parameter int DataWidth     = 32,
   parameter int RegAddr       = 2,
   parameter int MaxLockCycles = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]             lock_i,
   input  logic [NumReq*RegAddr-1:0]     addr_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*DataWidth/8-1:0] be_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          device_req_o,
   output logic [RegAddr-1:0]            device_addr_o,
   output logic                          device_we_o,
   output logic [DataWidth/8-1:0]        device_be_o,
   output logic [DataWidth-1:0]          device_wdata_o,
   input  logic [DataWidth-1:0]          device_rdata_i,
   output logic                          lock_timeout_o
);

   localparam int IdW  = $clog2(NumReq);
   localparam int BeW  = DataWidth / 8;
   localparam int CntW = $clog2(MaxLockCycles + 1);

   typedef logic [IdW-1:0] id_t;

   logic [RegAddr-1:0]   addr_a  [NumReq];
   logic [BeW-1:0]       be_a    [NumReq];
   logic [DataWidth-1:0] wdata_a [NumReq];

   for (genvar k = 0; k < NumReq; k++) begin : g_unpack
      assign addr_a[k]  = addr_i[k*RegAddr +: RegAddr];
      assign be_a[k]    = be_i[k*BeW +: BeW];
      assign wdata_a[k] = wdata_i[k*DataWidth +: DataWidth];
   end

   id_t            prio_q, prio_d;
   id_t            owner_q, owner_d;
   logic           lock_q, lock_d;
   logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
   logic           rsp_valid_q, rsp_valid_d;
   id_t            rsp_id_q, rsp_id_d;

   logic           hit;
   id_t            idx;
   id_t            cand;
   logic           timeout;

   function automatic id_t inc_id(input id_t i);
      if (int'(i) == NumReq - 1) return '0;
      return i + 1'b1;
   endfunction

   // Grant is masked in reset so every output reads zero there.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = prio_q;
      if (rst_ni) begin
         if (lock_q) begin
            if (req_i[owner_q]) begin
               hit = 1'b1;
               idx = owner_q;
            end
         end else begin
            for (int i = 0; i < NumReq; i++) begin
               if (!hit && req_i[cand]) begin
                  hit = 1'b1;
                  idx = cand;
               end
               cand = inc_id(cand);
            end
         end
      end
   end

   always_comb begin
      prio_d     = prio_q;
      owner_d    = owner_q;
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      timeout    = 1'b0;
      if (lock_q) begin
         if (hit) begin
            lock_cnt_d = '0;
            if (!lock_i[owner_q]) lock_d = 1'b0;
         end else if (lock_cnt_q == CntW'(MaxLockCycles - 1)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            prio_d     = inc_id(owner_q);
            timeout    = 1'b1;
         end else if (lock_cnt_q != CntW'(MaxLockCycles)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
         end
      end else if (hit) begin
         prio_d = inc_id(idx);
         if (lock_i[idx]) begin
            lock_d     = 1'b1;
            owner_d    = idx;
            lock_cnt_d = '0;
         end
      end
   end

   assign rsp_valid_d = hit;
   assign rsp_id_d    = idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q      <= '0;
         owner_q     <= '0;
         lock_q      <= 1'b0;
         lock_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         prio_q      <= prio_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         lock_cnt_q  <= lock_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   always_comb begin
      gnt_o = '0;
      if (hit) gnt_o[idx] = 1'b1;
      rvalid_o = '0;
      if (rsp_valid_q) rvalid_o[rsp_id_q] = 1'b1;
   end

   assign rdata_o        = rsp_valid_q ? device_rdata_i : '0;
   assign device_req_o   = hit;
   assign device_addr_o  = hit ? addr_a[idx] : '0;
   assign device_we_o    = hit ? we_i[idx] : 1'b0;
   assign device_be_o    = hit ? be_a[idx] : '0;
   assign device_wdata_o = hit ? wdata_a[idx] : '0;
   assign lock_timeout_o = timeout;

endmodule

// File: tb/tb_simple_uart_arbiter.sv
// Directed bench for simple_uart_arbiter with a response scoreboard.
module tb_simple_uart_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [3:0]  req_i = '0;
   logic [3:0]  lock_i = '0;
   logic [7:0]  addr_i;
   logic [3:0]  we_i;
   logic [15:0] be_i;
   logic [127:0] wdata_i;
   logic [3:0]  gnt_o;
   logic [3:0]  rvalid_o;
   logic [31:0] rdata_o;
   logic        device_req_o;
   logic [1:0]  device_addr_o;
   logic        device_we_o;
   logic [3:0]  device_be_o;
   logic [31:0] device_wdata_o;
   logic [31:0] device_rdata_i = '0;
   logic        lock_timeout_o;

   simple_uart_arbiter #(
      .NumReq(4), .DataWidth(32), .RegAddr(2), .MaxLockCycles(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i),
      .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .device_req_o(device_req_o), .device_addr_o(device_addr_o),
      .device_we_o(device_we_o), .device_be_o(device_be_o),
      .device_wdata_o(device_wdata_o), .device_rdata_i(device_rdata_i),
      .lock_timeout_o(lock_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  rv;
      logic [31:0] rd;
   } rsp_t;

   rsp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] rd_plan = '0;
   logic [1:0]  a_m  [4];
   logic [3:0]  be_m [4];
   logic [31:0] wd_m [4];
   logic [3:0]  we_m;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int k = 0; k < 4; k++) begin
         addr_i[k*2 +: 2]   = a_m[k];
         be_i[k*4 +: 4]     = be_m[k];
         wdata_i[k*32 +: 32] = wd_m[k];
      end
      we_i = we_m;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".gnt"}, 32'(gnt_o), 0);
      chk({tag, ".rvalid"}, 32'(rvalid_o), 0);
      chk({tag, ".rdata"}, rdata_o, 0);
      chk({tag, ".dreq"}, 32'(device_req_o), 0);
      chk({tag, ".daddr"}, 32'(device_addr_o), 0);
      chk({tag, ".dwdata"}, device_wdata_o, 0);
      chk({tag, ".timeout"}, 32'(lock_timeout_o), 0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      pack();
      #1;
      chk_quiet("rst_in");
      sb.delete();
      repeat (2) @(negedge clk_i);
      req_i = '0;
      lock_i = '0;
      rst_ni = 1'b1;
      rd_plan = '0;
      #1;
      chk_quiet("rst_out");
      @(negedge clk_i);
   endtask

   task automatic tick(input logic [3:0] eg, input logic eto,
                       input logic [31:0] nrd);
      rsp_t e;
      int   id;
      pack();
      device_rdata_i = rd_plan;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rvalid", 32'(rvalid_o), 32'(e.rv));
         chk("rdata", rdata_o, e.rd);
      end
      chk("gnt", 32'(gnt_o), 32'(eg));
      chk("timeout", 32'(lock_timeout_o), 32'(eto));
      chk("dreq", 32'(device_req_o), 32'(eg != 0));
      id = -1;
      for (int k = 0; k < 4; k++) if (eg[k]) id = k;
      if (id >= 0) begin
         chk("daddr", 32'(device_addr_o), 32'(a_m[id]));
         chk("dwe", 32'(device_we_o), 32'(we_m[id]));
         chk("dbe", 32'(device_be_o), 32'(be_m[id]));
         chk("dwdata", device_wdata_o, wd_m[id]);
      end else begin
         chk("daddr0", 32'(device_addr_o), 0);
         chk("dwdata0", device_wdata_o, 0);
      end
      rd_plan = nrd;
      sb.push_back('{rv: eg, rd: (eg != 0) ? nrd : 32'h0});
      @(negedge clk_i);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         a_m[k]  = 2'(k);
         be_m[k] = 4'hF ^ 4'(k);
         wd_m[k] = 32'h1000_0000 * k + 32'h55;
      end
      we_m = 4'b0101;
      req_i = 4'b0111;
      do_reset();

      // single requester write, then prio_q = 2 makes req3 win
      a_m[1] = 2'd0; we_m[1] = 1'b1; wd_m[1] = 32'h41;
      req_i = 4'b0010; tick(4'b0010, 1'b0, 32'h11);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'h12);
      req_i = 4'b1011; tick(4'b1000, 1'b0, 32'h13);
      req_i = 4'b0011; tick(4'b0001, 1'b0, 32'h14);
      req_i = 4'b0010; tick(4'b0010, 1'b0, 32'h15);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'h16);

      // round-robin reads, back-to-back responses
      do_reset();
      we_m = 4'b0000;
      req_i = 4'b1111;
      tick(4'b0001, 1'b0, 32'hA0);
      tick(4'b0010, 1'b0, 32'hA1);
      tick(4'b0100, 1'b0, 32'hA2);
      tick(4'b1000, 1'b0, 32'hA3);
      tick(4'b0001, 1'b0, 32'hA4);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'hA5);

      // locked three-word message from req1
      do_reset();
      we_m = 4'b1111;
      req_i = 4'b0001; tick(4'b0001, 1'b0, 32'hB0);
      req_i = 4'b0111; lock_i = 4'b0010; wd_m[1] = 32'hA1;
      tick(4'b0010, 1'b0, 32'hB1);
      wd_m[1] = 32'hA2; tick(4'b0010, 1'b0, 32'hB2);
      lock_i = 4'b0000; wd_m[1] = 32'hA3;
      tick(4'b0010, 1'b0, 32'hB3);
      req_i = 4'b0101; tick(4'b0100, 1'b0, 32'hB4);
      req_i = 4'b0001; tick(4'b0001, 1'b0, 32'hB5);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'hB6);

      // lock timeout after 8 idle cycles
      do_reset();
      req_i = 4'b1000; lock_i = 4'b1000;
      tick(4'b1000, 1'b0, 32'hC0);
      req_i = 4'b0001; lock_i = 4'b0000;
      for (int i = 0; i < 7; i++) tick(4'b0000, 1'b0, 32'hC1 + i);
      tick(4'b0000, 1'b1, 32'hC8);
      tick(4'b0001, 1'b0, 32'hC9);
      req_i = 4'b0011; tick(4'b0010, 1'b0, 32'hCA);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'hCB);

      // owner grant on the timeout cycle wins
      do_reset();
      req_i = 4'b1000; lock_i = 4'b1000;
      tick(4'b1000, 1'b0, 32'hD0);
      req_i = 4'b0001; lock_i = 4'b0000;
      for (int i = 0; i < 7; i++) tick(4'b0000, 1'b0, 32'hD1 + i);
      req_i = 4'b1001; tick(4'b1000, 1'b0, 32'hD8);
      req_i = 4'b0001; tick(4'b0001, 1'b0, 32'hD9);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'hDA);

      // read path
      do_reset();
      we_m[2] = 1'b0; a_m[2] = 2'd1;
      req_i = 4'b0100; tick(4'b0100, 1'b0, 32'hDEAD_BEEF);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'h0);

      // reset while locked with a response in flight
      do_reset();
      req_i = 4'b0001; tick(4'b0001, 1'b0, 32'hE0);
      req_i = 4'b0111; lock_i = 4'b0010;
      tick(4'b0010, 1'b0, 32'hE1);
      do_reset();
      req_i = 4'b0101; tick(4'b0001, 1'b0, 32'hE2);
      req_i = 4'b0100; tick(4'b0100, 1'b0, 32'hE3);
      req_i = 4'b0000; tick(4'b0000, 1'b0, 32'hE4);
      tick(4'b0000, 1'b0, 32'hE5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/simple_uart_arbiter.md
Name: simple_uart_arbiter

Overview:
- Shares one simple_uart_core register port (req/addr/we/be/wdata/rdata, 1-cycle read latency) between NumReq requesters, e.g. multiple cores printing to a single UART.
- Round-robin arbitration with an optional per-requester lock, so a multi-word message is not interleaved with other traffic.
- A lock timeout prevents one requester from starving the others.
- Sits between the requesters' device ports and simple_uart_core.

Parameters:
- NumReq, 4, number of requesters (2..16)
- DataWidth, 32, register data width
- RegAddr, 2, register word-address width
- MaxLockCycles, 256, maximum consecutive cycles a lock may be held before forced release (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester transfer request
- lock_i  in  NumReq  requester wants to keep ownership after this transfer
- addr_i  in  NumReq*RegAddr  packed word addresses, requester k at [k*RegAddr +: RegAddr]
- we_i  in  NumReq  write enable
- be_i  in  NumReq*DataWidth/8  byte enables
- wdata_i  in  NumReq*DataWidth  write data
- gnt_o  out  NumReq  one-hot grant; transfer accepted this cycle
- rvalid_o  out  NumReq  response valid, one cycle after grant
- rdata_o  out  DataWidth  response data, shared; qualified by rvalid_o
- device_req_o  out  1  to core
- device_addr_o  out  RegAddr  to core
- device_we_o  out  1  to core
- device_be_o  out  DataWidth/8  to core
- device_wdata_o  out  DataWidth  to core
- device_rdata_i  in  DataWidth  from core, valid one cycle after device_req_o
- lock_timeout_o  out  1  single-cycle pulse on forced lock release

Behaviour:
- Grant is combinational in the request cycle. The core is always ready, so one transfer is accepted per cycle at most.
- Requester k keeps req_i[k] and its payload stable until gnt_o[k] is seen.
- Unlocked arbitration: the winner is the first requesting index at or above prio_q, searching upward with wrap. On a grant to k, prio_q <= (k+1) mod NumReq.
- Locked arbitration: while lock_q is set, only owner_q can be granted. Other requests wait with gnt_o low. prio_q is not updated while locked.
- Lock set: on a grant to k with lock_i[k]=1, set lock_q=1, owner_q=k, lock_cnt_q=0.
- Lock release: on a grant to owner_q with lock_i low, clear lock_q.
- Lock count: while lock_q=1, lock_cnt_q increments every cycle, idle cycles included. A granted owner transfer with lock_i high restarts it at 0.
- Lock timeout: when lock_cnt_q reaches MaxLockCycles-1 with no owner grant that cycle:
  - clear lock_q;
  - set prio_q=(owner_q+1) mod NumReq;
  - pulse lock_timeout_o for one cycle.
  - The next cycle arbitrates unlocked.
- Timeout and grant in the same cycle: if the owner is granted in that cycle, the grant wins and the lock follows the normal rules.
- Core drive: device_req_o = |gnt_o. device_addr/we/be/wdata are muxed from the granted requester; all are zero when there is no grant.
- Response path:
  - rsp_valid_q <= |gnt_o; rsp_id_q <= granted index.
  - rvalid_o[rsp_id_q] = rsp_valid_q, for writes as well as reads.
  - rdata_o = device_rdata_i when rsp_valid_q, else 0.
  - Back-to-back grants yield back-to-back responses.
- Only NumReq requester indices exist, so no other encodings need handling.
- Reset values: prio_q=0, lock_q=0, owner_q=0, lock_cnt_q=0, rsp_valid_q=0, rsp_id_q=0. All outputs are 0 during and right after reset.
- Reset mid-lock or mid-response: the lock is dropped and no rvalid_o is issued for the in-flight transfer.
- lock_cnt_q width is $clog2(MaxLockCycles+1) and it never wraps.

Test Plan:
- Single requester: req_i=4'b0010 write addr 0 data 0x41 -> gnt_o=4'b0010 same cycle, device_req_o=1 with wdata 0x41; rvalid_o=4'b0010 the next cycle; prio_q=2.
- Round-robin: all four requesting continuously from reset, no lock -> grants cycle 0,1,2,3,0; each rvalid_o follows one cycle later; rdata_o matches device_rdata_i.
- Lock: req1 issues three writes with lock_i=1,1,0 while req0 and req2 request -> req1 gets three consecutive grants; req2 granted next, then req0.
- Lock timeout: MaxLockCycles=8, req3 granted with lock_i=1 then goes idle, req0 requesting -> lock_timeout_o pulses 8 cycles after the lock grant; req0 granted the next cycle; prio_q then 1.
- Read path: req2 reads addr 1 while the core returns 0xDEADBEEF on device_rdata_i the next cycle -> rvalid_o[2]=1 with rdata_o=0xDEADBEEF.
- Reset mid-lock: assert rst_ni low while owner=1 is locked and a response is pending -> all outputs are 0 afterwards; the first post-reset grant goes to the lowest requesting index.
